instruction_memory_server: RTL and testbench

Responder end of the engine instruction-memory read protocol: owns the program RAM and serves read requests from `2**ENGINE_ID_BITS` engines through a shared single-read-port RAM. Arbitration is round-robin with same-address coalescing. Each served word goes onto a shared data bus, and every completed read is broadcast so engine caches can snoop it. Sits between the host program loader (write port) and the engines' memory read ports inside the coprocessor.

---
 rtl/instruction_memory_server_pkg.sv | 18 +
 rtl/instruction_memory_server_rr_arbiter.sv | 38 +++
 rtl/instruction_memory_server.sv | 117 +++++++++++
 tb/tb_instruction_memory_server.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_memory_server_pkg.sv
// Shared coprocessor package for the instruction-memory server.
// Holds default geometry, the address/word typedefs for the default geometry,
// and the helper that turns an engine-id width into an engine count.
package instruction_memory_server_pkg;

  localparam int DEFAULT_MEMORY_WIDTH      = 16;
  localparam int DEFAULT_MEMORY_ADDR_WIDTH = 11;
  localparam int DEFAULT_ENGINE_ID_BITS    = 2;

  typedef logic [DEFAULT_MEMORY_ADDR_WIDTH-1:0] imem_addr_t;
  typedef logic [DEFAULT_MEMORY_WIDTH-1:0]      imem_word_t;

  // Number of requesting engines for a given engine-id width.
  function automatic int engine_count(input int id_bits);
    return 1 << id_bits;
  endfunction

endpackage

// File: rtl/instruction_memory_server_rr_arbiter.sv
// N-way round-robin arbiter.
// Scans the request vector upward starting at ptr, wrapping modulo N, and
// reports the first requester found.
//   req          in   N      request vector
//   ptr          in   IDX_W  index with highest priority this cycle
//   grant_onehot out  N      one-hot winner (all zero when req is zero)
//   winner_idx   out  IDX_W  binary index of the winner (0 when req is zero)
module instruction_memory_server_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] winner_idx
);

  logic             found;
  logic [IDX_W-1:0] scan_idx;

  always_comb begin
    found      = 1'b0;
    winner_idx = '0;
    scan_idx   = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[scan_idx]) begin
        found      = 1'b1;
        winner_idx = scan_idx;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign grant_onehot[gi] = found && (winner_idx == IDX_W'(gi));
  end

endmodule

// File: rtl/instruction_memory_server.sv
// Instruction-memory server: owns the program RAM and serves reads from
// 2**ENGINE_ID_BITS engines through one RAM read port.
// One cycle arbitrates and issues (round-robin winner plus every eligible port
// asking for the same address); the next cycle presents the response and
// broadcasts the completed address for cache snooping.
//   clk, rst        clock, synchronous active-high reset
//   req_valid       in   N        per-engine request, held until its resp_ready
//   req_addr        in   N*AW     per-engine address, slice i for engine i
//   resp_ready      out  N        served engines (multi-hot when coalesced)
//   resp_data       out  W        word read for the served engines
//   broadcast_valid out  1        a read completed this cycle
//   broadcast_addr  out  AW       address of that read
//   wr_en/addr/data in            host program-loader write port
//   served_count    out  32       completed reads, coalesced reads count once
module instruction_memory_server
  import instruction_memory_server_pkg::*;
#(
  parameter  int MEMORY_WIDTH      = DEFAULT_MEMORY_WIDTH,
  parameter  int MEMORY_ADDR_WIDTH = DEFAULT_MEMORY_ADDR_WIDTH,
  parameter  int ENGINE_ID_BITS    = DEFAULT_ENGINE_ID_BITS,
  localparam int N                 = engine_count(ENGINE_ID_BITS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N-1:0]                   req_valid,
  input  logic [N*MEMORY_ADDR_WIDTH-1:0] req_addr,
  output logic [N-1:0]                   resp_ready,
  output logic [MEMORY_WIDTH-1:0]        resp_data,
  output logic                           broadcast_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0]   broadcast_addr,
  input  logic                           wr_en,
  input  logic [MEMORY_ADDR_WIDTH-1:0]   wr_addr,
  input  logic [MEMORY_WIDTH-1:0]        wr_data,
  output logic [31:0]                    served_count
);

  logic [N-1:0]                 in_flight_reg;
  logic [ENGINE_ID_BITS-1:0]    rr_ptr_reg;
  logic [MEMORY_WIDTH-1:0]      rd_data_reg;
  logic [MEMORY_ADDR_WIDTH-1:0] bcast_addr_reg;
  logic [31:0]                  served_count_reg;

  logic [MEMORY_ADDR_WIDTH-1:0] port_addr [N];
  logic [N-1:0]                 eligible;
  logic [N-1:0]                 winner_onehot;
  logic [ENGINE_ID_BITS-1:0]    winner_idx;
  logic                         issue;
  logic [MEMORY_ADDR_WIDTH-1:0] issue_addr;
  logic [N-1:0]                 grant_next;

  logic [MEMORY_WIDTH-1:0] mem [2**MEMORY_ADDR_WIDTH];

  for (genvar gi = 0; gi < N; gi++) begin : g_addr_slice
    assign port_addr[gi] = req_addr[gi*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
  end

  // A port still holding valid during its response cycle is already being
  // answered; masking it here stops it being served twice for one request.
  assign eligible = req_valid & ~in_flight_reg;

  instruction_memory_server_rr_arbiter #(
    .N     (N),
    .IDX_W (ENGINE_ID_BITS)
  ) u_arb (
    .req          (eligible),
    .ptr          (rr_ptr_reg),
    .grant_onehot (winner_onehot),
    .winner_idx   (winner_idx)
  );

  assign issue      = |winner_onehot;
  assign issue_addr = port_addr[winner_idx];

  // Coalescing: every eligible port asking for the winner's address rides on
  // the same RAM read.
  for (genvar gi = 0; gi < N; gi++) begin : g_coalesce
    assign grant_next[gi] = winner_onehot[gi] |
                            (issue && eligible[gi] && (port_addr[gi] == issue_addr));
  end

  // Host write port. Kept apart from the read register so the array maps onto
  // block RAM; the read below sees the pre-write word (read-first).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight_reg    <= '0;
      rr_ptr_reg       <= '0;
      rd_data_reg      <= '0;
      bcast_addr_reg   <= '0;
      served_count_reg <= '0;
    end else begin
      in_flight_reg <= grant_next;
      if (issue) begin
        rd_data_reg      <= mem[issue_addr];
        bcast_addr_reg   <= issue_addr;
        // N is a power of two, so the natural wrap of the index width is
        // exactly modulo N.
        rr_ptr_reg       <= winner_idx + 1'b1;
        // Counted at issue so the value seen in the response cycle already
        // includes that response.
        served_count_reg <= served_count_reg + 32'd1;
      end
    end
  end

  assign resp_ready      = in_flight_reg;
  assign resp_data       = rd_data_reg;
  assign broadcast_valid = |in_flight_reg;
  assign broadcast_addr  = bcast_addr_reg;
  assign served_count    = served_count_reg;

endmodule

// File: tb/tb_instruction_memory_server.sv
// Randomised scoreboard bench for instruction_memory_server.
// The stimulus side runs a behavioural model of the arbitration rules and
// pushes each expected response into a queue; a negedge monitor pops and
// compares whenever the DUT shows a response.
module tb_instruction_memory_server;

  localparam int N  = 4;
  localparam int AW = 11;
  localparam int W  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    resp_ready;
  logic [W-1:0]    resp_data;
  logic            broadcast_valid;
  logic [AW-1:0]   broadcast_addr;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [W-1:0]    wr_data;
  logic [31:0]     served_count;

  instruction_memory_server #(
    .MEMORY_WIDTH      (W),
    .MEMORY_ADDR_WIDTH (AW),
    .ENGINE_ID_BITS    (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .resp_ready      (resp_ready),
    .resp_data       (resp_data),
    .broadcast_valid (broadcast_valid),
    .broadcast_addr  (broadcast_addr),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .served_count    (served_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [3:0]  mask;
    logic [15:0] data;
    logic [10:0] addr;
    logic [31:0] count;
  } sb_entry_t;

  sb_entry_t sb[$];
  sb_entry_t mon_e;

  int n_checks = 0;
  int n_err    = 0;

  // Stimulus drive values.
  logic [3:0]  v_drv;
  logic [10:0] a_drv [N];
  logic        we_drv;
  logic [10:0] wa_drv;
  logic [15:0] wd_drv;
  logic        rst_drv;

  // Reference model state.
  logic [15:0] m_mem [64];
  logic [3:0]  m_in_flight;
  int          m_ptr;
  logic [31:0] m_count;
  logic        owed    [N];
  int          free_at [N];
  int          since   [N];

  logic        mon_en      = 1'b0;
  int          zero_chk_cyc = -1;
  logic [3:0]  prev_rr     = '0;

  // Apply this cycle's inputs, advance the model, then move to just after
  // the next rising edge.
  task automatic tick();
    logic [3:0]  elig;
    logic [3:0]  grant;
    logic [10:0] wa;
    int          w;
    sb_entry_t   e;
    for (int i = 0; i < N; i++) begin
      if (v_drv[i] && !owed[i] && cyc >= free_at[i]) begin
        owed[i]  = 1'b1;
        since[i] = cyc;
      end
    end
    rst       = rst_drv;
    req_valid = v_drv;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = a_drv[i];
    wr_en   = we_drv;
    wr_addr = wa_drv;
    wr_data = wd_drv;
    if (rst_drv) begin
      m_in_flight = '0;
      m_ptr       = 0;
      m_count     = '0;
      for (int i = 0; i < N; i++) begin
        owed[i]    = 1'b0;
        free_at[i] = cyc + 1;
      end
    end else begin
      elig  = v_drv & ~m_in_flight;
      grant = '0;
      if (elig != 0) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        wa = a_drv[w];
        for (int i = 0; i < N; i++)
          if (elig[i] && a_drv[i] == wa) grant[i] = 1'b1;
        m_count = m_count + 32'd1;
        e.due   = cyc + 1;
        e.mask  = grant;
        e.data  = m_mem[wa[5:0]];
        e.addr  = wa;
        e.count = m_count;
        sb.push_back(e);
        m_ptr = (w + 1) % N;
        for (int i = 0; i < N; i++)
          if (grant[i]) begin
            owed[i]    = 1'b0;
            free_at[i] = cyc + 2;
          end
      end
      m_in_flight = grant;
    end
    if (we_drv) m_mem[wa_drv[5:0]] = wd_drv;
    @(posedge clk);
    #1;
  endtask

  // Drop requests once each has been answered, respecting the hold rule.
  task automatic release_all();
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++)
        if (v_drv[i] && !owed[i] && cyc >= free_at[i]) v_drv[i] = 1'b0;
      if (v_drv == 0) break;
      tick();
    end
    v_drv = '0;
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (cyc == zero_chk_cyc) begin
      n_checks++;
      if (resp_ready !== 4'b0 || broadcast_valid !== 1'b0 || broadcast_addr !== 11'd0 ||
          resp_data !== 16'd0 || served_count !== 32'd0) begin
        n_err++;
        $display("FAIL reset_state cyc=%0d got ready=%b bvalid=%b baddr=%0d data=%h count=%0d required all zero",
                 cyc, resp_ready, broadcast_valid, broadcast_addr, resp_data, served_count);
      end
    end
    if (mon_en) begin
      if (resp_ready != 4'b0) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_resp cyc=%0d got ready=%b required none", cyc, resp_ready);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.due != cyc || resp_ready !== mon_e.mask || resp_data !== mon_e.data ||
              broadcast_addr !== mon_e.addr || broadcast_valid !== 1'b1 ||
              served_count !== mon_e.count) begin
            n_err++;
            $display("FAIL resp cyc=%0d(due %0d) got ready=%b data=%h addr=%0d bvalid=%b count=%0d required ready=%b data=%h addr=%0d bvalid=1 count=%0d",
                     cyc, mon_e.due, resp_ready, resp_data, broadcast_addr, broadcast_valid,
                     served_count, mon_e.mask, mon_e.data, mon_e.addr, mon_e.count);
          end else begin
            $display("resp cyc=%0d ready=%b addr=%0d data=%h count=%0d",
                     cyc, resp_ready, broadcast_addr, resp_data, served_count);
          end
        end
        n_checks++;
        if ((resp_ready & prev_rr) != 4'b0) begin
          n_err++;
          $display("FAIL back_to_back cyc=%0d got ready=%b after %b required no repeated port",
                   cyc, resp_ready, prev_rr);
        end
        for (int i = 0; i < N; i++) begin
          if (resp_ready[i]) begin
            n_checks++;
            if (cyc - since[i] > N) begin
              n_err++;
              $display("FAIL fairness cyc=%0d port=%0d got wait=%0d required <= %0d",
                       cyc, i, cyc - since[i], N);
            end
          end
        end
      end else begin
        n_checks++;
        if (broadcast_valid !== 1'b0 || (sb.size() != 0 && sb[0].due <= cyc)) begin
          n_err++;
          $display("FAIL missing_resp cyc=%0d got ready=0000 bvalid=%b required pending=%0d",
                   cyc, broadcast_valid, sb.size());
          if (sb.size() != 0 && sb[0].due <= cyc) void'(sb.pop_front());
        end
      end
      prev_rr = resp_ready;
    end
  end

  initial begin
    v_drv   = '0;
    we_drv  = 1'b0;
    wa_drv  = '0;
    wd_drv  = '0;
    rst_drv = 1'b1;
    m_in_flight = '0;
    m_ptr   = 0;
    m_count = '0;
    for (int i = 0; i < N; i++) begin
      a_drv[i]   = '0;
      owed[i]    = 1'b0;
      free_at[i] = 0;
      since[i]   = 0;
    end

    // Reset; the outputs are checked in the cycle after the first reset edge.
    zero_chk_cyc = cyc + 1;
    tick();
    tick();
    rst_drv = 1'b0;
    mon_en  = 1'b1;

    // Preload the model-covered region; address 8 holds 0x00AA for the
    // collision case.
    for (int a = 0; a < 64; a++) begin
      we_drv = 1'b1;
      wa_drv = 11'(a);
      wd_drv = (a == 8) ? 16'h00AA : 16'($urandom);
      tick();
    end
    we_drv = 1'b0;

    // Round-robin from reset: four ports, distinct addresses, held.
    v_drv = 4'b1111;
    for (int i = 0; i < N; i++) a_drv[i] = 11'(i + 1);
    for (int n = 0; n < 12; n++) tick();
    release_all();
    tick();

    // Single read of 0xBEEF at address 5 (leaves the pointer at 1).
    we_drv = 1'b1; wa_drv = 11'd5; wd_drv = 16'hBEEF;
    tick();
    we_drv = 1'b0;
    v_drv = 4'b0001; a_drv[0] = 11'd5;
    tick(); tick();
    release_all();
    tick();

    // Coalescing: ports 1 and 3 on address 7, port 2 on address 9.
    v_drv = 4'b1110; a_drv[1] = 11'd7; a_drv[2] = 11'd9; a_drv[3] = 11'd7;
    tick(); tick();
    release_all();
    tick();

    // Read/write collision on address 8, then read it back.
    we_drv = 1'b1; wa_drv = 11'd8; wd_drv = 16'h1234;
    v_drv = 4'b0001; a_drv[0] = 11'd8;
    tick();
    we_drv = 1'b0;
    tick();
    release_all();
    v_drv = 4'b0001; a_drv[0] = 11'd8;
    tick(); tick();
    release_all();
    tick();

    // Held valid on port 2.
    v_drv = 4'b0100; a_drv[2] = 11'd20;
    for (int n = 0; n < 6; n++) tick();
    release_all();
    tick();

    // Random traffic: a fully contended stretch, then a mixed one.
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (v_drv[i]) begin
          if (!owed[i] && cyc >= free_at[i]) begin
            if (c < 150 || $urandom_range(1, 0) == 1) a_drv[i] = 11'($urandom_range(15, 0));
            else v_drv[i] = 1'b0;
          end
        end else if (c < 150 || $urandom_range(9, 0) < 3) begin
          v_drv[i] = 1'b1;
          a_drv[i] = 11'($urandom_range(15, 0));
        end
      end
      we_drv = ($urandom_range(4, 0) == 0);
      wa_drv = 11'($urandom_range(15, 0));
      wd_drv = 16'($urandom);
      tick();
    end
    we_drv = 1'b0;
    release_all();
    tick();

    // Reset in the cycle after a grant; the response already issued is seen,
    // everything is zero in the cycle after reset.
    v_drv = 4'b0010; a_drv[1] = 11'd3;
    tick();
    rst_drv = 1'b1;
    zero_chk_cyc = cyc + 1;
    tick();
    rst_drv = 1'b0;
    v_drv = 4'b0000;
    tick();

    // Pointer must be back at 0: port 0 wins over port 3.
    v_drv = 4'b1001; a_drv[0] = 11'd10; a_drv[3] = 11'd11;
    tick(); tick();
    release_all();
    for (int n = 0; n < 4; n++) tick();

    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain got pending=%0d required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
